// File: rtl/program_loader.sv
// Boot-time program loader for the single-cycle RISC-V core.
// Consumes a byte stream (2-byte little-endian word count, N little-endian
// 32-bit instruction words, 1 XOR checksum byte). Each assembled word is
// written to instruction memory, and the core is held in reset until a load
// finishes with a matching checksum.
module program_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  // The word count is 16 bits, so DEPTH is compared in 17 bits. This keeps
  // ADDR_W = 16 (DEPTH = 65536) exact.
  localparam logic [16:0] DEPTH_W = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_CSUM,
    S_DONE
  } state_e;

  state_e              state_q,      state_d;
  logic [15:0]         count_q,      count_d;
  logic [15:0]         word_idx_q,   word_idx_d;
  logic [1:0]          byte_idx_q,   byte_idx_d;
  logic [23:0]         asm_q,        asm_d;
  logic [7:0]          csum_q,       csum_d;
  logic                rx_ready_q,   rx_ready_d;
  logic                imem_we_q,    imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q,  imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                cpu_hold_q,   cpu_hold_d;
  logic                done_q,       done_d;
  logic                err_q,        err_d;

  logic                xfer;
  logic [15:0]         hdr_count;

  // A byte moves only when both sides agree. rx_ready is registered, so it
  // is the flop value that qualifies the transfer.
  assign xfer      = rx_valid && rx_ready_q;
  assign hdr_count = {rx_data, count_q[7:0]};

  // Next-state and next-output logic for the loader FSM.
  always_comb begin
    // NOTE: every _d starts from its held value (imem_we from 0), so no path
    // through the case below leaves a variable unassigned and infers a latch.
    state_d      = state_q;
    count_d      = count_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    csum_d       = csum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_hold_d   = cpu_hold_q;
    done_d       = done_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_HDR0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          csum_d     = 8'h00;
          cpu_hold_d = 1'b1;
          byte_idx_d = 2'd0;
          word_idx_d = 16'd0;
        end
      end

      S_HDR0: begin
        if (xfer) begin
          count_d[7:0] = rx_data;
          csum_d       = csum_q ^ rx_data;
          state_d      = S_HDR1;
        end
      end

      S_HDR1: begin
        if (xfer) begin
          count_d    = hdr_count;
          csum_d     = csum_q ^ rx_data;
          word_idx_d = 16'd0;
          byte_idx_d = 2'd0;
          if (hdr_count == 16'd0) begin
            state_d = S_CSUM;
          end else if ({1'b0, hdr_count} > DEPTH_W) begin
            // The image cannot fit in memory. Abort before any byte is
            // written, and keep the core in reset.
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
          csum_d     = csum_q ^ rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q != 2'd3) begin
            asm_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
          end else begin
            // The fourth byte completes the word. The write strobe is
            // registered, so it fires in the next cycle while rx_ready stays
            // high for the following byte.
            imem_we_d    = 1'b1;
            imem_addr_d  = word_idx_q[ADDR_W-1:0];
            imem_wdata_d = {rx_data, asm_q};
            word_idx_d   = word_idx_q + 16'd1;
            if (word_idx_q == count_q - 16'd1) begin
              state_d = S_CSUM;
            end
          end
        end
      end

      S_CSUM: begin
        if (xfer) begin
          state_d = S_DONE;
          if (rx_data == csum_q) begin
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // rx_ready is registered from the next state, so it is high exactly in
    // the byte-accepting states.
    rx_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) ||
                 (state_d == S_DATA) || (state_d == S_CSUM);
  end

  // State, counters and registered outputs. Reset drops any pending write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples pre-edge values and the update order does not matter.
      state_q      <= S_IDLE;
      count_q      <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      csum_q       <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      csum_q       <= csum_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader (ADDR_W=4, DEPTH=16).
// A reference model parses each byte stream and predicts the memory writes
// and the final done/err/cpu_hold state. The stimulus is random programs
// with random rx_valid gaps, plus the directed scenarios.
module tb_program_loader;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk;
  logic              reset;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Stimulus stream and model predictions.
  logic [7:0]  stream_q[$];
  int          exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  bit          exp_done;
  bit          exp_err;

  // Writes and protocol anomalies seen on the DUT outputs.
  int          obs_addr_q[$];
  logic [31:0] obs_data_q[$];
  int          wide_pulses;
  int          both_set;
  logic        we_prev;

  // Monitor: samples 1 ns after each rising edge.
  always @(posedge clk) begin
    #1;
    if (imem_we) begin
      obs_addr_q.push_back(int'(imem_addr));
      obs_data_q.push_back(imem_wdata);
    end
    if (imem_we && we_prev) wide_pulses++;
    if (done && err) both_set++;
    we_prev = imem_we;
  end

  // Reference model. It parses the whole stream as a boot image.
  task automatic model();
    int cnt;
    logic [7:0] x;
    exp_addr_q.delete();
    exp_data_q.delete();
    cnt = int'(stream_q[0]) + 256 * int'(stream_q[1]);
    x   = stream_q[0] ^ stream_q[1];
    if (cnt > DEPTH) begin
      exp_err  = 1'b1;
      exp_done = 1'b0;
      return;
    end
    for (int i = 0; i < cnt; i++) begin
      logic [31:0] w;
      w = '0;
      for (int k = 0; k < 4; k++) begin
        w = w | (32'(stream_q[2 + 4 * i + k]) << (8 * k));
        x = x ^ stream_q[2 + 4 * i + k];
      end
      exp_addr_q.push_back(i % DEPTH);
      exp_data_q.push_back(w);
    end
    exp_done = (stream_q[2 + 4 * cnt] == x);
    exp_err  = !exp_done;
  endtask

  // Build a random image: n words, then a checksum that may be corrupted.
  task automatic gen_stream(input int n, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    stream_q.delete();
    stream_q.push_back(n[7:0]);
    stream_q.push_back(n[15:8]);
    if (n > DEPTH) return;
    x = n[7:0] ^ n[15:8];
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      stream_q.push_back(b);
      x = x ^ b;
    end
    if (corrupt) x = x ^ (8'd1 << $urandom_range(0, 7));
    stream_q.push_back(x);
  endtask

  task automatic load_normal(input logic [7:0] last);
    stream_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                 8'h13, 8'h01, 8'h10, 8'h00, last};
  endtask

  // Called at a negedge; returns at a negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int bound;
    bound    = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    if (!rx_ready) check("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Send bytes [0, upto) with random gaps. A start pulse is injected before
  // byte index inject_at; -1 disables the injection.
  task automatic send_stream(input int upto, input int gap_max, input int inject_at);
    for (int i = 0; i < upto; i++) begin
      int gap;
      gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      if (i == inject_at) pulse_start();
      repeat (gap) @(negedge clk);
      send_byte(stream_q[i]);
    end
  endtask

  task automatic clear_obs();
    obs_addr_q.delete();
    obs_data_q.delete();
    wide_pulses = 0;
    both_set    = 0;
  endtask

  // One full load from start to final outputs, checked against the model.
  task automatic run_load(input string tag, input int gap_max, input int inject_at);
    int n;
    model();
    clear_obs();
    pulse_start();
    send_stream(stream_q.size(), gap_max, inject_at);
    repeat (3) @(negedge clk);
    check({tag, "_nwr"}, 32'(obs_addr_q.size()), 32'(exp_addr_q.size()));
    n = (obs_addr_q.size() < exp_addr_q.size()) ? obs_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(obs_addr_q[i]), 32'(exp_addr_q[i]));
      check($sformatf("%s_data%0d", tag, i), obs_data_q[i], exp_data_q[i]);
    end
    check({tag, "_done"},  32'(done),     32'(exp_done));
    check({tag, "_err"},   32'(err),      32'(exp_err));
    check({tag, "_hold"},  32'(cpu_hold), 32'(!exp_done));
    check({tag, "_rdy"},   32'(rx_ready), 32'd0);
    check({tag, "_wide"},  32'(wide_pulses), 32'd0);
    check({tag, "_both"},  32'(both_set),    32'd0);
    // The result level must persist while idle in DONE.
    repeat (8) @(negedge clk);
    check({tag, "_done_hold"}, 32'(done), 32'(exp_done));
    check({tag, "_err_hold"},  32'(err),  32'(exp_err));
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    we_prev  = 1'b0;
    clear_obs();
    repeat (3) @(negedge clk);
    check("rst_hold",  32'(cpu_hold),   32'd1);
    check("rst_done",  32'(done),       32'd0);
    check("rst_err",   32'(err),        32'd0);
    check("rst_rdy",   32'(rx_ready),   32'd0);
    check("rst_we",    32'(imem_we),    32'd0);
    check("rst_addr",  32'(imem_addr),  32'd0);
    check("rst_wdata", imem_wdata,      32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Normal load from the worked example.
    load_normal(8'hC3);
    run_load("normal", 0, -1);
    if (obs_data_q.size() == 2) begin
      check("ex_w0", obs_data_q[0], 32'h00500093);
      check("ex_w1", obs_data_q[1], 32'h00100113);
    end

    // Zero length.
    stream_q = '{8'h00, 8'h00, 8'h00};
    run_load("zero", 0, -1);

    // Overflow: 17 words > DEPTH 16.
    stream_q = '{8'h11, 8'h00};
    run_load("ovf", 0, -1);

    // Bad checksum.
    load_normal(8'hC2);
    run_load("badcs", 0, -1);

    // Backpressure, 0-5 idle cycles between bytes.
    load_normal(8'hC3);
    run_load("bp", 5, -1);

    // Exactly DEPTH words is legal.
    gen_stream(DEPTH, 1'b0);
    run_load("full", 2, -1);

    // A start pulse in the middle of DATA must be ignored.
    load_normal(8'hC3);
    run_load("midstart", 1, 5);

    // Reset mid-load after byte 0x50.
    load_normal(8'hC3);
    clear_obs();
    pulse_start();
    send_stream(5, 0, -1);
    reset = 1'b0;
    #1;
    check("mrst_hold", 32'(cpu_hold), 32'd1);
    check("mrst_rdy",  32'(rx_ready), 32'd0);
    check("mrst_we",   32'(imem_we),  32'd0);
    check("mrst_done", 32'(done),     32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_idle_rdy", 32'(rx_ready), 32'd0);
    check("mrst_nwr", 32'(obs_addr_q.size()), 32'd0);
    run_load("after_rst", 3, -1);

    // Random images, random checksum corruption, random gaps.
    for (int t = 0; t < 25; t++) begin
      int n;
      if ($urandom_range(0, 5) == 0) n = $urandom_range(DEPTH + 1, 600);
      else n = $urandom_range(0, DEPTH);
      gen_stream(n, ($urandom_range(0, 3) == 0));
      run_load($sformatf("rnd%0d", t), $urandom_range(0, 5), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
